// File: rtl/pokey_serout_ctrl.sv
// ---------------------------------------------------------------------------
// pokey_serout_ctrl
//
// Sequencer for the POKEY serial-output shift chain. The chain itself is
// built from falling-edge load/reset cells outside this block; this module
// only produces the strobes those cells sample. A single CPU byte is buffered
// in a holding register and sent as start bit (0), eight data bits LSB first,
// then stop bit (1). The first tick after the parallel load ends the start
// bit, so the start bit is shorter than the other bits.
//
// Ports
//   clk          system clock; state changes on the rising edge
//   R            synchronous active-high reset
//   wr_en        one-cycle CPU write strobe to SEROUT
//   wr_data      SEROUT byte
//   bit_tick     one-cycle baud tick from the audio timer (>= 3 cycles apart)
//   force_break  SKCTL break, forces sout low
//   sr_q0        Q of chain cell 0 (the bit currently on the line)
//   sr_clr       R input of every chain cell (follows R combinationally)
//   sr_en        enable of every chain cell
//   sr_ld        1 = parallel load of par_d, 0 (with sr_en) = shift toward bit 0
//   par_d        frame {stop, data[7:0], start} built from the held byte
//   sout         serial line
//   need_irq     one-cycle pulse when the held byte is taken for transmission
//   xmt_done     level, idle with nothing held
// ---------------------------------------------------------------------------
module pokey_serout_ctrl #(
  parameter int FRAME_BITS = 10
) (
  input  logic                  clk,
  input  logic                  R,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  bit_tick,
  input  logic                  force_break,
  input  logic                  sr_q0,
  output logic                  sr_clr,
  output logic                  sr_en,
  output logic                  sr_ld,
  output logic [FRAME_BITS-1:0] par_d,
  output logic                  sout,
  output logic                  need_irq,
  output logic                  xmt_done
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_hold;
  logic             r_hold_full;
  logic             w_hold_full_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_need_irq;
  logic             w_need_irq_next;
  logic             w_consume;
  logic             w_en;
  logic             w_ld;

  // State register
  always_ff @(posedge clk) begin
    if (R) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
      r_need_irq  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_hold_full <= w_hold_full_next;
      r_cnt       <= w_cnt_next;
      r_need_irq  <= w_need_irq_next;
      if (wr_en) begin
        r_hold <= wr_data;
      end
    end
  end

  // Next state and strobe decode
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_need_irq_next = 1'b0;
    w_consume       = 1'b0;
    w_en            = 1'b0;
    w_ld            = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (r_hold_full) begin
          w_state_next = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // bit_tick is deliberately ignored here; the start bit simply
        // lasts until the first tick seen in SHIFT.
        w_en            = 1'b1;
        w_ld            = 1'b1;
        w_consume       = 1'b1;
        w_need_irq_next = 1'b1;
        w_cnt_next      = '0;
        w_state_next    = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (bit_tick) begin
          if (r_cnt != LAST_BIT) begin
            w_en       = 1'b1;
            w_cnt_next = r_cnt + 1'b1;
          end else begin
            // Stop bit complete: no shift, the stop level stays on the
            // line through a following LOAD cycle.
            w_state_next = r_hold_full ? ST_LOAD : ST_IDLE;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // A write coinciding with consumption wins: the new byte stays held.
    if (wr_en) begin
      w_hold_full_next = 1'b1;
    end else if (w_consume) begin
      w_hold_full_next = 1'b0;
    end else begin
      w_hold_full_next = r_hold_full;
    end
  end

  // Strobes are suppressed while reset is asserted so a reset landing on a
  // LOAD or tick cycle cannot disturb the chain being cleared.
  assign sr_clr   = R;
  assign sr_en    = w_en & ~R;
  assign sr_ld    = w_ld & ~R;
  assign par_d    = {1'b1, r_hold, 1'b0};
  assign need_irq = r_need_irq;
  assign xmt_done = R | ((r_state == ST_IDLE) & ~r_hold_full);

  always_comb begin
    if (force_break) begin
      sout = 1'b0;
    end else if (R || (r_state != ST_SHIFT)) begin
      sout = 1'b1;
    end else begin
      sout = sr_q0;
    end
  end

endmodule

// File: tb/tb_pokey_serout_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for pokey_serout_ctrl. Includes a behavioural model of the
// falling-edge shift chain so sr_q0 reflects the strobes the DUT issues.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled
// 3 time units after it, the chain moves on the falling edge (5 units).
// ---------------------------------------------------------------------------
module tb_pokey_serout_ctrl;

  logic       clk = 1'b0;
  logic       R;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       bit_tick;
  logic       force_break;
  logic       sr_q0;
  logic       sr_clr;
  logic       sr_en;
  logic       sr_ld;
  logic [9:0] par_d;
  logic       sout;
  logic       need_irq;
  logic       xmt_done;

  pokey_serout_ctrl #(.FRAME_BITS(10)) dut (
    .clk        (clk),
    .R          (R),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .bit_tick   (bit_tick),
    .force_break(force_break),
    .sr_q0      (sr_q0),
    .sr_clr     (sr_clr),
    .sr_en      (sr_en),
    .sr_ld      (sr_ld),
    .par_d      (par_d),
    .sout       (sout),
    .need_irq   (need_irq),
    .xmt_done   (xmt_done)
  );

  always #5 clk = ~clk;

  // Shift-chain model: falling-edge cells, shift fills with 1
  logic [9:0] chain = '1;
  always @(negedge clk) begin
    if (sr_clr)
      chain <= '0;
    else if (sr_en)
      chain <= sr_ld ? par_d : {1'b1, chain[9:1]};
  end
  assign sr_q0 = chain[0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Baud ticks every 8 cycles when enabled
  logic tick_on = 1'b0;
  initial begin
    bit_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bit_tick = tick_on && ((cyc % 8) == 0);
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard entries: one per frame expected on the line
  typedef struct {
    logic [9:0] par;
    logic       brk;
    logic       b2b;
    logic       chk_lat;
    int         wr_cyc;
  } exp_t;
  exp_t exp_q[$];

  // Monitor state
  exp_t       cur;
  logic       collecting = 1'b0;
  int         bitcnt = 0;
  int         nshift = 0;
  logic [9:0] line_bits;
  int         frames_done = 0;
  int         irq_count = 0;
  int         last_end_cyc = 0;
  int         ld_cyc = 0;
  logic       ld_valid = 1'b0;
  logic       exp_irq;
  logic [9:0] exp_line;

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (R) begin
        collecting = 1'b0;
        ld_valid   = 1'b0;
      end else begin
        exp_irq = ld_valid && (cyc == ld_cyc + 1);
        if (need_irq || exp_irq)
          check("need_irq_timing", need_irq, exp_irq);
        if (need_irq)
          irq_count++;
        if (sr_ld) begin
          if (collecting)
            check("frame_cut_short", bitcnt, 10);
          if (exp_q.size() == 0) begin
            check("unexpected_load", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            check("par_d", par_d, cur.par);
            if (cur.chk_lat)
              check("write_to_load_latency", cyc - cur.wr_cyc, 2);
            if (cur.b2b)
              check("b2b_load_gap", cyc - last_end_cyc, 1);
            collecting = 1'b1;
            bitcnt     = 0;
            nshift     = 0;
            ld_cyc     = cyc;
            ld_valid   = 1'b1;
          end
        end else begin
          if (sr_en) begin
            if (collecting && bit_tick)
              nshift++;
            else
              check("stray_shift_strobe", sr_en, 0);
          end
          if (collecting && bit_tick) begin
            line_bits[bitcnt] = sout;
            bitcnt++;
            if (bitcnt == 10) begin
              exp_line = cur.brk ? 10'b0 : cur.par;
              check("line_bits", line_bits, exp_line);
              check("shift_count", nshift, 9);
              $display("frame %0d: par_d=%b line=%b shifts=%0d", frames_done, cur.par, line_bits, nshift);
              collecting   = 1'b0;
              frames_done++;
              last_end_cyc = cyc;
            end
          end
        end
      end
    end
  end

  // Driver helpers (called at posedge+1)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic [9:0] par,
                            input logic sent, input logic b2b, input logic lat);
    exp_t e;
    e.par = par; e.brk = force_break; e.b2b = b2b; e.chk_lat = lat; e.wr_cyc = cyc;
    if (sent) exp_q.push_back(e);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      step();
      n++;
    end
    check("frames_completed", frames_done, target);
  endtask

  task automatic check_idle(input string tag, input logic exp_sout);
    step();
    step();
    #2;
    check({tag, "_xmt_done"}, xmt_done, 1);
    check({tag, "_sout"}, sout, exp_sout);
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  int irq0;
  int f0;
  int bad;
  int n;
  logic seen;

  initial begin
    R = 1'b1; wr_en = 1'b1; wr_data = 8'h77; force_break = 1'b0;

    // Reset held 3 cycles with a write pending
    for (int i = 0; i < 3; i++) begin
      step();
      #2;
      check("rst_sr_clr", sr_clr, 1);
      check("rst_xmt_done", xmt_done, 1);
      check("rst_sout", sout, 1);
      check("rst_sr_en", sr_en, 0);
      check("rst_sr_ld", sr_ld, 0);
    end
    step();
    R = 1'b0; wr_en = 1'b0;
    tick_on = 1'b1;
    repeat (20) step();
    #2;
    check("post_rst_xmt_done", xmt_done, 1);
    check("post_rst_sout", sout, 1);
    check("post_rst_sr_clr", sr_clr, 0);
    step();

    // Single byte 0xA5
    irq0 = irq_count; f0 = frames_done;
    write_byte(8'hA5, 10'b1101001010, 1'b1, 1'b0, 1'b1);
    wait_frames(f0 + 1, 400);
    check_idle("a5", 1'b1);
    check("a5_irq_pulses", irq_count - irq0, 1);

    // Back-to-back 0x3C then 0xC3
    irq0 = irq_count; f0 = frames_done;
    write_byte(8'h3C, 10'b1001111000, 1'b1, 1'b0, 1'b1);
    repeat (20) step();
    write_byte(8'hC3, 10'b1110000110, 1'b1, 1'b1, 1'b0);
    bad = 0; n = 0;
    while (frames_done < f0 + 2 && n < 600) begin
      #1;
      if (xmt_done) bad++;
      step();
      n++;
    end
    check("b2b_xmt_done_busy", bad, 0);
    check("b2b_frames", frames_done, f0 + 2);
    check_idle("b2b", 1'b1);
    check("b2b_irq_pulses", irq_count - irq0, 2);

    // Overwrite: 0x11 replaced by 0x22 while busy
    irq0 = irq_count; f0 = frames_done;
    write_byte(8'h55, 10'b1010101010, 1'b1, 1'b0, 1'b1);
    repeat (15) step();
    write_byte(8'h11, 10'b1000100010, 1'b0, 1'b0, 1'b0);
    step();
    write_byte(8'h22, 10'b1001000100, 1'b1, 1'b1, 1'b0);
    wait_frames(f0 + 2, 600);
    check_idle("ovw", 1'b1);
    check("ovw_irq_pulses", irq_count - irq0, 2);

    // Collision: write in the LOAD cycle is kept
    irq0 = irq_count; f0 = frames_done;
    write_byte(8'h5A, 10'b1010110100, 1'b1, 1'b0, 1'b1);
    seen = 1'b0; n = 0;
    while (!seen && n < 10) begin
      #2;
      if (sr_ld) seen = 1'b1;
      else begin step(); n++; end
    end
    check("coll_load_seen", seen, 1);
    write_byte(8'h96, 10'b1100101100, 1'b1, 1'b1, 1'b0);
    wait_frames(f0 + 2, 600);
    check_idle("coll", 1'b1);
    check("coll_irq_pulses", irq_count - irq0, 2);

    // Break during a frame
    irq0 = irq_count; f0 = frames_done;
    force_break = 1'b1;
    write_byte(8'h81, 10'b1100000010, 1'b1, 1'b0, 1'b1);
    wait_frames(f0 + 1, 400);
    check_idle("brk", 1'b0);
    check("brk_irq_pulses", irq_count - irq0, 1);
    force_break = 1'b0;
    step();

    // Abort at cnt=4 with a byte pending
    irq0 = irq_count;
    write_byte(8'h0F, 10'b1000011110, 1'b1, 1'b0, 1'b1);
    n = 0;
    while (!(collecting && bitcnt == 4) && n < 200) begin
      step();
      n++;
    end
    check("abort_reached_cnt4", bitcnt, 4);
    write_byte(8'hEE, 10'b1111011100, 1'b0, 1'b0, 1'b0);
    R = 1'b1;
    #2;
    check("abort_sr_clr", sr_clr, 1);
    check("abort_sr_en", sr_en, 0);
    check("abort_sout", sout, 1);
    step();
    R = 1'b0;
    #2;
    check("abort_next_xmt_done", xmt_done, 1);
    check("abort_next_sr_en", sr_en, 0);
    check("abort_next_need_irq", need_irq, 0);
    check("abort_next_sout", sout, 1);
    step();
    repeat (60) step();
    #2;
    check("abort_idle_xmt_done", xmt_done, 1);
    check("abort_irq_pulses", irq_count - irq0, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
